// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: once-per-frame game sequencer for the pong display path.
// Advances the game FSM on each frame_tick, moves paddles and ball, handles
// wall/paddle bounces and scoring, and publishes registered object positions.
// Ports:
//   vga_clk        pixel clock (only clock)
//   sys_rst_n      synchronous active-low reset
//   frame_tick     one-cycle pulse per frame; all updates happen on it
//   start_n        start button, active-low, sampled on frame_tick
//   key0/key1      paddle keys, active-low: bit1 = up, bit0 = down
//   ball_x/ball_y  ball top-left corner
//   paddle0_y/1_y  paddle top edges
//   score0/score1  player scores (saturating)
//   game_state     IDLE=0 SERVE=1 PLAY=2 SCORE=3 OVER=4
//   winner         winning player, valid in OVER
module pong_game_ctrl #(
    parameter int unsigned H_DISP       = 640,
    parameter int unsigned V_DISP       = 480,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned PAD_W        = 8,
    parameter int unsigned PAD_H        = 64,
    parameter int unsigned PAD_X0       = 16,
    parameter int unsigned PAD_X1       = 616,
    parameter int unsigned BALL_SPEED   = 2,
    parameter int unsigned PAD_SPEED    = 4,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned WIN_SCORE    = 7
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic       frame_tick,
    input  logic       start_n,
    input  logic [1:0] key0,
    input  logic [1:0] key1,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle0_y,
    output logic [9:0] paddle1_y,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic [2:0] game_state,
    output logic       winner
);

    localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);

    // 11-bit working constants so sums of 10-bit coordinates never overflow
    localparam logic [10:0] L_BSZ     = 11'(BALL_SIZE);
    localparam logic [10:0] L_BSPD    = 11'(BALL_SPEED);
    localparam logic [10:0] L_PSPD    = 11'(PAD_SPEED);
    localparam logic [10:0] L_PAD_H   = 11'(PAD_H);
    localparam logic [10:0] L_PAD_MAX = 11'(V_DISP - PAD_H);
    localparam logic [10:0] L_BY_MAX  = 11'(V_DISP - BALL_SIZE);
    localparam logic [10:0] L_BX_MAX  = 11'(H_DISP - BALL_SIZE);
    localparam logic [10:0] L_FACE0   = 11'(PAD_X0 + PAD_W);
    localparam logic [10:0] L_FACE0_R = 11'(PAD_X0 + PAD_W + BALL_SPEED);
    localparam logic [10:0] L_FACE1   = 11'(PAD_X1);
    localparam logic [10:0] L_MISS_R  = 11'(H_DISP - BALL_SPEED);
    localparam logic [9:0]  L_BX_CTR  = 10'((H_DISP - BALL_SIZE) / 2);
    localparam logic [9:0]  L_BY_CTR  = 10'((V_DISP - BALL_SIZE) / 2);
    localparam logic [9:0]  L_PAD_CTR = 10'((V_DISP - PAD_H) / 2);
    localparam logic [3:0]  L_WIN     = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] L_SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        SCORE = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t           state;
    logic             dir_right;
    logic             dir_down;
    logic [CNT_W-1:0] serve_cnt;

    // Clamped paddle step; compare before subtracting so y never wraps
    function automatic logic [9:0] pad_step(input logic [9:0] y, input logic [1:0] key);
        logic [10:0] y11;
        y11      = {1'b0, y};
        pad_step = y;
        if (!key[1] && key[0]) begin
            pad_step = (y11 <= L_PSPD) ? 10'd0 : 10'(y11 - L_PSPD);
        end else if (key[1] && !key[0]) begin
            pad_step = (y11 + L_PSPD >= L_PAD_MAX) ? 10'(L_PAD_MAX) : 10'(y11 + L_PSPD);
        end
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        sat_inc = (s == 4'hF) ? s : s + 4'd1;
    endfunction

    logic [10:0] bx, by, p0, p1;
    logic        ov0, ov1, hit_l, hit_r, miss_l, miss_r;
    logic [9:0]  p0_nxt, p1_nxt, bx_play, by_play;
    logic        dir_down_play, dir_right_play;

    assign bx = {1'b0, ball_x};
    assign by = {1'b0, ball_y};
    assign p0 = {1'b0, paddle0_y};
    assign p1 = {1'b0, paddle1_y};
    assign game_state = state;

    // Next-frame ball/paddle candidates for PLAY, all from pre-update values
    always_comb begin
        p0_nxt         = pad_step(paddle0_y, key0);
        p1_nxt         = pad_step(paddle1_y, key1);
        ov0            = (by + L_BSZ > p0) && (by < p0 + L_PAD_H);
        ov1            = (by + L_BSZ > p1) && (by < p1 + L_PAD_H);
        hit_l          = !dir_right && (bx >= L_FACE0) && (bx <= L_FACE0_R) && ov0;
        hit_r          = dir_right && (bx + L_BSZ <= L_FACE1)
                         && (bx + L_BSPD + L_BSZ >= L_FACE1) && ov1;
        miss_l         = !dir_right && (bx <= L_BSPD) && !hit_l;
        miss_r         = dir_right && (bx + L_BSZ >= L_MISS_R) && !hit_r;
        dir_down_play  = dir_down;
        dir_right_play = dir_right;
        by_play        = ball_y;
        bx_play        = ball_x;

        if (dir_down) begin
            if (by + L_BSPD >= L_BY_MAX) begin
                by_play       = 10'(L_BY_MAX);
                dir_down_play = 1'b0;
            end else begin
                by_play = 10'(by + L_BSPD);
            end
        end else if (by <= L_BSPD) begin
            by_play       = 10'd0;
            dir_down_play = 1'b1;
        end else begin
            by_play = 10'(by - L_BSPD);
        end

        if (hit_l) begin
            bx_play        = 10'(L_FACE0);
            dir_right_play = 1'b1;
        end else if (hit_r) begin
            bx_play        = 10'(L_FACE1 - L_BSZ);
            dir_right_play = 1'b0;
        end else if (miss_l) begin
            bx_play = 10'd0;
        end else if (miss_r) begin
            bx_play = 10'(L_BX_MAX);
        end else if (dir_right) begin
            bx_play = 10'(bx + L_BSPD);
        end else begin
            bx_play = 10'(bx - L_BSPD);
        end
    end

    // Game FSM and registered outputs; everything advances only on frame_tick
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            ball_x    <= L_BX_CTR;
            ball_y    <= L_BY_CTR;
            paddle0_y <= L_PAD_CTR;
            paddle1_y <= L_PAD_CTR;
            score0    <= 4'd0;
            score1    <= 4'd0;
            winner    <= 1'b0;
            dir_right <= 1'b1;
            dir_down  <= 1'b1;
            serve_cnt <= '0;
        end else if (frame_tick) begin
            case (state)
                IDLE: begin
                    if (!start_n) begin
                        score0    <= 4'd0;
                        score1    <= 4'd0;
                        serve_cnt <= '0;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    paddle0_y <= p0_nxt;
                    paddle1_y <= p1_nxt;
                    if (serve_cnt == L_SERVE_LAST) begin
                        serve_cnt <= '0;
                        state     <= PLAY;
                    end else begin
                        serve_cnt <= serve_cnt + CNT_W'(1);
                    end
                end
                PLAY: begin
                    paddle0_y <= p0_nxt;
                    paddle1_y <= p1_nxt;
                    ball_x    <= bx_play;
                    ball_y    <= by_play;
                    dir_right <= dir_right_play;
                    dir_down  <= dir_down_play;
                    if (miss_l) begin
                        score1 <= sat_inc(score1);
                        state  <= SCORE;
                    end else if (miss_r) begin
                        score0 <= sat_inc(score0);
                        state  <= SCORE;
                    end
                end
                SCORE: begin
                    // dir_x still points at the conceding side, so the serve goes toward it
                    if (score0 == L_WIN || score1 == L_WIN) begin
                        winner <= (score0 != L_WIN);
                        state  <= OVER;
                    end else begin
                        ball_x   <= L_BX_CTR;
                        ball_y   <= L_BY_CTR;
                        dir_down <= 1'b1;
                        state    <= SERVE;
                    end
                end
                OVER: begin
                    if (!start_n) begin
                        score0    <= 4'd0;
                        score1    <= 4'd0;
                        ball_x    <= L_BX_CTR;
                        ball_y    <= L_BY_CTR;
                        serve_cnt <= '0;
                        state     <= SERVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Per-frame game sequencer for the pong display path. Sits between the VGA timing/display blocks and the player keys. Once per video frame it advances the game state machine, moves the paddles and ball, detects collisions and scoring, and publishes registered object positions that vga_display renders.

Parameters:
H_DISP, 640, active horizontal pixels
V_DISP, 480, active vertical lines
BALL_SIZE, 8, ball edge length in pixels (square)
PAD_W, 8, paddle width in pixels
PAD_H, 64, paddle height in pixels
PAD_X0, 16, left x of player-0 paddle
PAD_X1, 616, left x of player-1 paddle
BALL_SPEED, 2, ball step per frame on each axis
PAD_SPEED, 4, paddle step per frame
SERVE_FRAMES, 60, frames ball is held centred before play
WIN_SCORE, 7, score that ends the game

Ports:
vga_clk  in  1  pixel clock; the only clock
sys_rst_n  in  1  synchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame, at start of vertical blanking
start_n  in  1  start button, active-low, sampled only on frame_tick
key0  in  2  player-0 paddle keys, active-low: bit1 = up, bit0 = down
key1  in  2  player-1 paddle keys, same encoding
ball_x  out  10  ball left x
ball_y  out  10  ball top y
paddle0_y  out  10  player-0 paddle top y
paddle1_y  out  10  player-1 paddle top y
score0  out  4  player-0 score
score1  out  4  player-1 score
game_state  out  3  IDLE=0, SERVE=1, PLAY=2, SCORE=3, OVER=4
winner  out  1  winning player; valid in OVER

Behaviour:
- One clock (vga_clk). Reset is synchronous and active-low. Reset wins over frame_tick in the same cycle, including mid-game.
- All outputs are registered and change only on a cycle where frame_tick=1. Between ticks every output holds. Update latency is 1 clock after the tick.
- Reset values:
  - state IDLE
  - ball_x = (H_DISP-BALL_SIZE)/2 = 316
  - ball_y = (V_DISP-BALL_SIZE)/2 = 236
  - paddle0_y = paddle1_y = (V_DISP-PAD_H)/2 = 208
  - scores 0, winner 0
  - internal dir_x = right, dir_y = down, serve counter 0
- Paddles (SERVE and PLAY only):
  - Up only pressed: y = max(0, y-PAD_SPEED).
  - Down only pressed: y = min(V_DISP-PAD_H, y+PAD_SPEED).
  - Both or neither pressed: hold.
  - Compare before subtracting; no 10-bit underflow or wrap is allowed.
- IDLE: ball and paddles held. On a tick with start_n=0: clear scores, clear serve counter, go to SERVE.
- SERVE: ball held at centre. Serve counter increments each tick. On the tick where counter = SERVE_FRAMES-1: counter clears, go to PLAY.
- PLAY, per tick, both axes evaluated in the same tick:
  - Vertical, moving down: if y+BALL_SPEED >= V_DISP-BALL_SIZE, then y = V_DISP-BALL_SIZE and dir_y flips to up. Otherwise y += BALL_SPEED.
  - Vertical, moving up: if y <= BALL_SPEED, then y = 0 and dir_y flips to down. Otherwise y -= BALL_SPEED.
  - Left hit: moving left with x >= PAD_X0+PAD_W and x-BALL_SPEED <= PAD_X0+PAD_W, and vertical overlap with paddle0. Overlap means ball_y+BALL_SIZE > paddle0_y and ball_y < paddle0_y+PAD_H, using pre-update values. Result: x = PAD_X0+PAD_W, dir_x = right.
  - Right hit: mirror of left hit. Condition is x+BALL_SIZE <= PAD_X1 and x+BALL_SPEED+BALL_SIZE >= PAD_X1, with overlap against paddle1. Result: x = PAD_X1-BALL_SIZE, dir_x = left.
  - Left miss: moving left with x <= BALL_SPEED and no hit. x = 0, score1++, go to SCORE.
  - Right miss: moving right with x+BALL_SIZE >= H_DISP-BALL_SPEED and no hit. x = H_DISP-BALL_SIZE, score0++, go to SCORE.
  - Otherwise x moves BALL_SPEED in dir_x.
- SCORE (one tick):
  - If either score = WIN_SCORE: winner = that player, go to OVER.
  - Otherwise: recentre ball, set dir_x toward the player who conceded, dir_y = down, go to SERVE.
  - Scores saturate at 15 and never wrap.
- OVER: all positions, scores and winner held. On a tick with start_n=0: clear scores, recentre ball, go to SERVE.
- game_state always reflects the registered state.

Test Plan:
- Reset mid-PLAY, with frame_tick asserted in the same cycle -> next clock all outputs equal reset values (316/236/208/208/0/0, state 0).
- start_n=0 on a tick in IDLE -> state 1. After 60 further ticks -> state 2. First PLAY tick: ball 318/238.
- key0=2'b01 (up) held 60 ticks from 208 -> paddle0_y decrements by 4, reaches 0 on tick 52, stays 0. key0=2'b00 -> no change.
- Ball moving down at y=470 in PLAY -> next tick y=472 and moving up. Following tick y=470. No frame_tick for 1000 clocks -> nothing changes.
- Ball moving left at x=26, y=300, paddle0_y=0 (no overlap) -> no bounce, x reaches 0, score1=1, state 3, then state 1 with ball at 316/236 moving left. Same run with paddle0_y=260 -> x=24 and ball moving right.
- score1=6, then player-0 miss -> score1=7, state 4, winner=1, further ticks hold everything. start_n=0 on a tick -> state 1, scores 0.
